median_ctrl: RTL

- Sequencer and wrapper around the 9-tap median cell (MED).
- Accepts a burst of P pixels from the upstream window extractor and drives the cell's DSI/BYP schedule.
- Reports the median on DO with a one-cycle DSO strobe.
- Sits between the 3x3 window generator and the output pixel writer.

---
 rtl/median_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/median_ctrl.sv
// Sequencer around a 9-tap median cell: loads a window, runs four bubble passes plus a final
// max search, and presents the median on do_o with a one-cycle dso_o strobe.
module median_ctrl #(
  parameter int unsigned W = 8,
  parameter int unsigned P = 9
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] di_i,
  input  logic         dsi_i,
  output logic [W-1:0] do_o,
  output logic         dso_o,
  output logic         busy_o,
  output logic         err_o
);

  if (P != 9) begin : g_p_check
    $error("median_ctrl: the pass schedule is defined for P=9 only");
  end

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StPass  = 3'd2;
  localparam logic [2:0] StFinal = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] step_q, step_d;
  logic [2:0] pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       cell_dsi, cell_byp, err;
  logic [3:0] pass_limit;

  assign pass_limit = 4'd7 - {1'b0, pass_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    pass_d   = pass_q;
    cell_dsi = 1'b0;
    cell_byp = 1'b1;
    err      = 1'b0;
    unique case (state_q)
      // A sample accepted in IDLE or DONE is load cycle 1, so it must reach the cell too.
      StIdle: begin
        cell_dsi = dsi_i;
        if (dsi_i) begin
          state_d = StLoad;
          cnt_d   = 4'd1;
        end
      end
      StLoad: begin
        cell_dsi = dsi_i;
        if (dsi_i) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            state_d = StPass;
            pass_d  = 3'd0;
            step_d  = 4'd0;
          end
        end else begin
          err     = 1'b1;
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      StPass: begin
        err      = dsi_i;
        // Compare steps shrink by one per pass; the tail steps park earlier maxima.
        cell_byp = (step_q > pass_limit);
        if (step_q == 4'd8) begin
          step_d = 4'd0;
          if (pass_q == 3'd3) begin
            state_d = StFinal;
          end else begin
            pass_d = pass_q + 3'd1;
          end
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      StFinal: begin
        err      = dsi_i;
        cell_byp = 1'b0;
        if (step_q == 4'd3) begin
          state_d = StDone;
          step_d  = 4'd0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      StDone: begin
        cell_dsi = dsi_i;
        if (dsi_i) begin
          state_d = StLoad;
          cnt_d   = 4'd1;
        end else begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
        step_d  = 4'd0;
        pass_d  = 3'd0;
      end
    endcase
  end

  assign busy_d = (state_d != StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      step_q  <= 4'd0;
      pass_q  <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
    end
  end

  // Median cell. Load shifts into r[0]; bypass rotates the full ring; a compare step rotates
  // r[0..P-2] while r[P-1] keeps the larger of itself and the element leaving r[P-2].
  logic [W-1:0] r_q [P];
  logic [W-1:0] r_d [P];
  logic [W-1:0] tail_max, tail_min;

  assign tail_max = (r_q[P-1] >= r_q[P-2]) ? r_q[P-1] : r_q[P-2];
  assign tail_min = (r_q[P-1] >= r_q[P-2]) ? r_q[P-2] : r_q[P-1];

  always_comb begin
    r_d = r_q;
    if (cell_dsi) begin
      r_d[0] = di_i;
      for (int i = 1; i < int'(P); i++) r_d[i] = r_q[i-1];
    end else if (cell_byp) begin
      r_d[0] = r_q[P-1];
      for (int i = 1; i < int'(P); i++) r_d[i] = r_q[i-1];
    end else begin
      r_d[0] = tail_min;
      for (int i = 1; i < int'(P) - 1; i++) r_d[i] = r_q[i-1];
      r_d[P-1] = tail_max;
    end
  end

  always_ff @(posedge clk_i) begin
    r_q <= r_d;
  end

  assign do_o   = r_q[P-1];
  assign dso_o  = (state_q == StDone);
  assign busy_o = busy_q;
  assign err_o  = err;

endmodule
